// File: rtl/axi_slave_mem_if.sv
// AXI channel bundle between a master and axi_slave_mem.
// The slave modport is the memory side; master is the requester side.
interface axi_slave_mem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [ID_WIDTH-1:0]     wid;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_slave_mem.sv
// AXI slave memory with independent write and read FSMs (FIXED/INCR/WRAP).
// Define AXI_SLV_ADDR_CHECK_EN to answer out-of-range beats with DECERR.
module axi_slave_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 1024
) (
    input logic            aclk,
    input logic            arst,
    axi_slave_mem_if.slave bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LG = $clog2(NB);
    localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [ID_WIDTH-1:0]   id_t;

    typedef enum logic [1:0] { W_IDLE, W_DATA, W_RESP } w_state_t;
    typedef enum logic       { R_IDLE, R_DATA }         r_state_t;

    function automatic addr_t next_addr(addr_t a, logic [7:0] len,
                                        logic [2:0] size, logic [1:0] burst);
        addr_t nb;
        addr_t wl;
        addr_t base;
        nb   = addr_t'(1) << size;
        wl   = (addr_t'(len) + addr_t'(1)) * nb;
        base = a & ~(wl - addr_t'(1));
        case (burst)
            2'b01:   next_addr = (a & ~(nb - addr_t'(1))) + nb;
            2'b10:   next_addr = base + ((a + nb) & (wl - addr_t'(1)));
            default: next_addr = a;
        endcase
    endfunction

    function automatic logic bad_fields(logic [7:0] len, logic [2:0] size,
                                        logic [1:0] burst);
        logic wrap_bad;
        wrap_bad   = (burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
        bad_fields = (burst == 2'b11) || (int'(size) > LG) || wrap_bad;
    endfunction

    function automatic addr_t word_full(addr_t a);
        word_full = a >> LG;
    endfunction

    function automatic logic [IW-1:0] word_idx(addr_t a);
        word_idx = IW'(word_full(a) % addr_t'(MEM_DEPTH));
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    w_state_t   w_state_q, w_state_d;
    id_t        w_id_q, w_id_d;
    addr_t      w_addr_q, w_addr_d;
    logic [7:0] w_len_q, w_len_d;
    logic [2:0] w_size_q, w_size_d;
    logic [1:0] w_burst_q, w_burst_d;
    logic [7:0] w_cnt_q, w_cnt_d;
    logic       w_err_q, w_err_d;
    logic       w_lerr_q, w_lerr_d;
    logic       w_derr_q, w_derr_d;
    logic       w_we, w_oor;
    logic       awready, wready, bvalid;

    r_state_t   r_state_q, r_state_d;
    id_t        r_id_q, r_id_d;
    addr_t      r_addr_q, r_addr_d;
    logic [7:0] r_len_q, r_len_d;
    logic [2:0] r_size_q, r_size_d;
    logic [1:0] r_burst_q, r_burst_d;
    logic [7:0] r_cnt_q, r_cnt_d;
    logic       r_err_q, r_err_d;
    logic       r_oor;
    logic       arready, rvalid;

`ifdef AXI_SLV_ADDR_CHECK_EN
    assign w_oor = word_full(w_addr_q) >= addr_t'(MEM_DEPTH);
    assign r_oor = word_full(r_addr_q) >= addr_t'(MEM_DEPTH);
`else
    assign w_oor = 1'b0;
    assign r_oor = 1'b0;
`endif

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        w_lerr_d  = w_lerr_q;
        w_derr_d  = w_derr_q;
        w_we      = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                awready = 1'b1;
                if (bus.awvalid) begin
                    w_id_d    = bus.awid;
                    w_addr_d  = bus.awaddr;
                    w_len_d   = bus.awlen;
                    w_size_d  = bus.awsize;
                    w_burst_d = bus.awburst;
                    w_cnt_d   = 8'd0;
                    w_err_d   = bad_fields(bus.awlen, bus.awsize, bus.awburst);
                    w_lerr_d  = 1'b0;
                    w_derr_d  = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                wready = 1'b1;
                if (bus.wvalid) begin
                    w_we     = !w_err_q && !w_oor;
                    w_derr_d = w_derr_q | w_oor;
                    // wlast is only checked; the counted beat ends the burst
                    if (bus.wlast != (w_cnt_q == w_len_q))
                        w_lerr_d = 1'b1;
                    w_addr_d = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
                    w_cnt_d  = w_cnt_q + 8'd1;
                    if (w_cnt_q == w_len_q)
                        w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bus.bready)
                    w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            w_lerr_q  <= 1'b0;
            w_derr_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            w_lerr_q  <= w_lerr_d;
            w_derr_q  <= w_derr_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_we && !arst) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.wstrb[b])
                    mem_q[word_idx(w_addr_q)][b*8 +: 8] <= bus.wdata[b*8 +: 8];
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        r_err_d   = r_err_q;
        arready   = 1'b0;
        rvalid    = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                arready = 1'b1;
                if (bus.arvalid) begin
                    r_id_d    = bus.arid;
                    r_addr_d  = bus.araddr;
                    r_len_d   = bus.arlen;
                    r_size_d  = bus.arsize;
                    r_burst_d = bus.arburst;
                    r_cnt_d   = 8'd0;
                    r_err_d   = bad_fields(bus.arlen, bus.arsize, bus.arburst);
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (bus.rready) begin
                    r_addr_d = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
                    r_cnt_d  = r_cnt_q + 8'd1;
                    if (r_cnt_q == r_len_q)
                        r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_cnt_q   <= '0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_cnt_q   <= r_cnt_d;
            r_err_q   <= r_err_d;
        end
    end

    // Everything is forced low while reset is held, not just after the edge
    logic bv_o, rv_o;
    assign bv_o        = bvalid & ~arst;
    assign rv_o        = rvalid & ~arst;
    assign bus.awready = awready & ~arst;
    assign bus.wready  = wready & ~arst;
    assign bus.arready = arready & ~arst;
    assign bus.bvalid  = bv_o;
    assign bus.bid     = bv_o ? w_id_q : '0;
    assign bus.bresp   = !bv_o                 ? 2'b00 :
                         (w_err_q || w_lerr_q) ? 2'b10 :
                         w_derr_q              ? 2'b11 : 2'b00;
    assign bus.rvalid  = rv_o;
    assign bus.rid     = rv_o ? r_id_q : '0;
    assign bus.rlast   = rv_o && (r_cnt_q == r_len_q);
    assign bus.rdata   = (!rv_o || r_err_q || r_oor) ? '0 : mem_q[word_idx(r_addr_q)];
    assign bus.rresp   = !rv_o   ? 2'b00 :
                         r_err_q ? 2'b10 :
                         r_oor   ? 2'b11 : 2'b00;
endmodule

// File: tb/tb_axi_slave_mem.sv
// Scoreboard bench for axi_slave_mem: bursts, strobes, backpressure, reset, errors.
module tb_axi_slave_mem;
    logic aclk = 1'b0;
    logic arst;
    always #5 aclk = ~aclk;

    axi_slave_mem_if bus ();

    axi_slave_mem dut (
        .aclk (aclk),
        .arst (arst),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] model [1024];
    logic [31:0] wd [16];

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [1:0]  resp;
        logic [3:0]  id;
    } rexp_t;
    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rexp_t rq[$];
    bexp_t bq[$];

    function automatic int widx(logic [31:0] a);
        return int'((a >> 2) % 32'd1024);
    endfunction

    function automatic logic [31:0] tb_next(logic [31:0] a, logic [7:0] len,
                                            logic [2:0] size, logic [1:0] burst);
        logic [31:0] nb, wl, base;
        nb = 32'd1 << size;
        wl = (32'(len) + 32'd1) * nb;
        if (burst == 2'b01)
            return (a / nb) * nb + nb;
        if (burst == 2'b10) begin
            base = (a / wl) * wl;
            return base + ((a + nb) % wl);
        end
        return a;
    endfunction

    function automatic bit tb_err(logic [7:0] len, logic [2:0] size, logic [1:0] burst);
        if (burst == 2'b11) return 1'b1;
        if (size > 3'd2) return 1'b1;
        if (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
            return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic idle_inputs();
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0;
        bus.awburst = '0; bus.awvalid = 1'b0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
        bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
        bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit ok;
        int n = 0;
        bus.awid = id; bus.awaddr = a; bus.awlen = len;
        bus.awsize = size; bus.awburst = burst; bus.awvalid = 1'b1;
        #1;
        do begin
            ok = bus.awready;
            @(posedge aclk); @(negedge aclk);
            n++;
        end while (!ok && n < 50);
        bus.awvalid = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL aw_timeout got=awready 0 want=1");
        end
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit ok;
        int n = 0;
        bus.arid = id; bus.araddr = a; bus.arlen = len;
        bus.arsize = size; bus.arburst = burst; bus.arvalid = 1'b1;
        #1;
        do begin
            ok = bus.arready;
            @(posedge aclk); @(negedge aclk);
            n++;
        end while (!ok && n < 50);
        bus.arvalid = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL ar_timeout got=arready 0 want=1");
        end
    endtask

    task automatic w_beat();
        bit ok;
        int n = 0;
        #1;
        do begin
            ok = bus.wready;
            @(posedge aclk); @(negedge aclk);
            n++;
        end while (!ok && n < 50);
        if (!ok) begin
            total++; bad++;
            $display("FAIL w_timeout got=wready 0 want=1");
        end
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input logic [3:0] strb, input int badbeat,
                               input logic [1:0] exp_resp, input int bdelay);
        logic [31:0] aa = a;
        bit err = tb_err(len, size, burst);
        bit ok;
        int n = 0;
        bexp_t e;
        bq.push_back('{id: id, resp: exp_resp});
        aw_send(id, a, len, size, burst);
        for (int i = 0; i <= int'(len); i++) begin
            bus.wdata = wd[i];
            bus.wstrb = strb;
            bus.wlast = (i == int'(len)) ^ (i == badbeat);
            bus.wvalid = 1'b1;
            w_beat();
            if (!err) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) model[widx(aa)][b*8 +: 8] = wd[i][b*8 +: 8];
            end
            aa = tb_next(aa, len, size, burst);
        end
        bus.wvalid = 1'b0;
        bus.wlast = 1'b0;
        for (int k = 0; k < bdelay; k++) begin
            #1;
            total++;
            if (bus.bvalid !== 1'b1 || bus.bid !== id || bus.awready !== 1'b0) begin
                bad++;
                $display("FAIL b_hold got=bvalid %b bid %h awready %b want=1 %h 0",
                         bus.bvalid, bus.bid, bus.awready, id);
            end
            @(posedge aclk); @(negedge aclk);
        end
        bus.bready = 1'b1;
        #1;
        do begin
            ok = bus.bvalid;
            if (ok) begin
                e = bq.pop_front();
                total++;
                if (bus.bid !== e.id || bus.bresp !== e.resp) begin
                    bad++;
                    $display("FAIL bresp got=id %h resp %b want=id %h resp %b",
                             bus.bid, bus.bresp, e.id, e.resp);
                end
            end
            @(posedge aclk); @(negedge aclk);
            n++;
        end while (!ok && n < 50);
        bus.bready = 1'b0;
        if (!ok) begin
            total++; bad++;
            bq.delete();
            $display("FAIL b_timeout got=bvalid 0 want=1");
        end
        #1;
        total++;
        if (bus.awready !== 1'b1) begin
            bad++;
            $display("FAIL awready_after_b got=%b want=1", bus.awready);
        end
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input bit toggle);
        logic [31:0] aa = a;
        logic [31:0] held = '0;
        bit err = tb_err(len, size, burst);
        bit rr = 1'b1;
        bit stalled = 1'b0;
        int cyc = 0;
        rexp_t e;
        for (int i = 0; i <= int'(len); i++) begin
            rq.push_back('{data: err ? 32'h0 : model[widx(aa)], last: (i == int'(len)),
                           resp: err ? 2'b10 : 2'b00, id: id});
            aa = tb_next(aa, len, size, burst);
        end
        ar_send(id, a, len, size, burst);
        while (rq.size() > 0 && cyc < 200) begin
            bus.rready = toggle ? rr : 1'b1;
            rr = !rr;
            #1;
            if (stalled) begin
                total++;
                if (bus.rvalid !== 1'b1 || bus.rdata !== held) begin
                    bad++;
                    $display("FAIL r_stall got=rvalid %b rdata %h want=1 %h",
                             bus.rvalid, bus.rdata, held);
                end
            end
            if (bus.rvalid && bus.rready) begin
                e = rq.pop_front();
                stalled = 1'b0;
                total++;
                if (bus.rdata !== e.data || bus.rlast !== e.last ||
                    bus.rresp !== e.resp || bus.rid !== e.id) begin
                    bad++;
                    $display("FAIL r_beat got=%h last %b resp %b id %h want=%h last %b resp %b id %h",
                             bus.rdata, bus.rlast, bus.rresp, bus.rid,
                             e.data, e.last, e.resp, e.id);
                end
            end else if (bus.rvalid) begin
                stalled = 1'b1;
                held = bus.rdata;
            end
            @(posedge aclk); @(negedge aclk);
            cyc++;
        end
        bus.rready = 1'b0;
        if (rq.size() > 0) begin
            total++; bad++;
            $display("FAIL r_timeout got=%0d beats left want=0", rq.size());
            rq.delete();
        end
        #1;
        total++;
        if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
            bad++;
            $display("FAIL r_idle got=rvalid %b arready %b want=0 1", bus.rvalid, bus.arready);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        arst = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        #1;
        total++;
        if ({bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=00000",
                     {bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid});
        end
        arst = 1'b0;
        #1;
        total++;
        if (bus.awready !== 1'b1 || bus.arready !== 1'b1 || bus.wready !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got=aw %b ar %b w %b want=1 1 0",
                     bus.awready, bus.arready, bus.wready);
        end
        @(posedge aclk); @(negedge aclk);
    endtask

    task automatic test_single();
        wd[0] = 32'hDEADBEEF;
        write_burst(4'd5, 32'h10, 8'd0, 3'd2, 2'b01, 4'hF, -1, 2'b00, 0);
        read_burst(4'd9, 32'h10, 8'd0, 3'd2, 2'b01, 1'b0);
    endtask

    task automatic test_incr();
        for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
        write_burst(4'd1, 32'h100, 8'd3, 3'd2, 2'b01, 4'hF, -1, 2'b00, 0);
        read_burst(4'd2, 32'h100, 8'd3, 3'd2, 2'b01, 1'b0);
    endtask

    task automatic test_wrap();
        wd[0] = 32'hA1A1A1A1; wd[1] = 32'hB2B2B2B2;
        wd[2] = 32'hC3C3C3C3; wd[3] = 32'hD4D4D4D4;
        write_burst(4'd3, 32'h38, 8'd3, 3'd2, 2'b10, 4'hF, -1, 2'b00, 0);
        read_burst(4'd4, 32'h38, 8'd3, 3'd2, 2'b10, 1'b0);
        read_burst(4'd6, 32'h30, 8'd1, 3'd2, 2'b01, 1'b0);
        total++;
        if (model[12] !== 32'hC3C3C3C3 || model[13] !== 32'hD4D4D4D4) begin
            bad++;
            $display("FAIL wrap_order got=%h %h want=c3c3c3c3 d4d4d4d4", model[12], model[13]);
        end
    endtask

    task automatic test_strobe();
        wd[0] = 32'hFFFFFFFF;
        write_burst(4'd1, 32'h80, 8'd0, 3'd2, 2'b01, 4'hF, -1, 2'b00, 0);
        wd[0] = 32'h00000000;
        write_burst(4'd1, 32'h80, 8'd0, 3'd2, 2'b01, 4'h5, -1, 2'b00, 0);
        total++;
        if (model[32] !== 32'hFF00FF00) begin
            bad++;
            $display("FAIL strobe_model got=%h want=ff00ff00", model[32]);
        end
        read_burst(4'd1, 32'h80, 8'd0, 3'd2, 2'b01, 1'b0);
    endtask

    task automatic test_backpressure();
        wd[0] = 32'h5A5A0F0F;
        write_burst(4'd7, 32'h40, 8'd0, 3'd2, 2'b01, 4'hF, -1, 2'b00, 5);
        read_burst(4'd8, 32'h100, 8'd3, 3'd2, 2'b01, 1'b1);
        read_burst(4'd8, 32'h38, 8'd3, 3'd2, 2'b10, 1'b1);
    endtask

    task automatic test_reset_midburst();
        logic [31:0] aa = 32'h200;
        for (int i = 0; i < 8; i++) wd[i] = 32'h1000 + 32'(i);
        write_burst(4'd3, 32'h200, 8'd7, 3'd2, 2'b01, 4'hF, -1, 2'b00, 0);
        ar_send(4'd4, 32'h200, 8'd7, 3'd2, 2'b01);
        bus.rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (bus.rvalid !== 1'b1 || bus.rdata !== model[widx(aa)]) begin
                bad++;
                $display("FAIL mid_beat got=rvalid %b rdata %h want=1 %h",
                         bus.rvalid, bus.rdata, model[widx(aa)]);
            end
            aa = tb_next(aa, 8'd7, 3'd2, 2'b01);
            @(posedge aclk); @(negedge aclk);
        end
        arst = 1'b1;
        @(posedge aclk); @(negedge aclk);
        bus.rready = 1'b0;
        #1;
        total++;
        if (bus.rvalid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_rvalid got=%b want=0", bus.rvalid);
        end
        arst = 1'b0;
        #1;
        total++;
        if (bus.arready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_arready got=%b want=1", bus.arready);
        end
        @(posedge aclk); @(negedge aclk);
        read_burst(4'd5, 32'h20C, 8'd1, 3'd2, 2'b01, 1'b0);
    endtask

    task automatic test_errors();
        wd[0] = 32'h12345678;
        write_burst(4'd2, 32'h10, 8'd0, 3'd2, 2'b11, 4'hF, -1, 2'b10, 0);
        read_burst(4'd2, 32'h10, 8'd0, 3'd2, 2'b01, 1'b0);
        read_burst(4'd3, 32'h10, 8'd1, 3'd2, 2'b11, 1'b0);
        read_burst(4'd3, 32'h10, 8'd0, 3'd3, 2'b01, 1'b0);
        wd[0] = 32'h0BADBAD0; wd[1] = 32'h0BADBAD1; wd[2] = 32'h0BADBAD2;
        write_burst(4'd4, 32'h100, 8'd2, 3'd2, 2'b10, 4'hF, -1, 2'b10, 0);
        read_burst(4'd4, 32'h100, 8'd3, 3'd2, 2'b01, 1'b0);
        wd[0] = 32'h0000000A; wd[1] = 32'h0000000B;
        write_burst(4'd6, 32'h300, 8'd1, 3'd2, 2'b01, 4'hF, 0, 2'b10, 0);
        read_burst(4'd6, 32'h300, 8'd1, 3'd2, 2'b01, 1'b0);
        wd[0] = 32'h77777777;
        write_burst(4'd9, 32'h304, 8'd0, 3'd2, 2'b00, 4'hF, -1, 2'b00, 0);
        read_burst(4'd9, 32'h300, 8'd2, 3'd2, 2'b00, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_incr();
        test_wrap();
        test_strobe();
        test_backpressure();
        test_reset_midburst();
        test_errors();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
